logic_reduce_pipe: RTL and testbench
====================================

// Module: logic_reduce_pipe
// PURPOSE
//  Parametrised, pipelined successor to the 3-input combinational gate cells.
//  Combines N_IN operands of WIDTH bits bit-wise with a runtime-selected gate op.
//  Result is registered with fixed 2-cycle latency behind a valid/ready handshake.
//  Sits between a producer and a consumer on the datapath; stalls under backpressure.
// PARAMETERS
//  N_IN   default 3  number of operands, >=2
//  WIDTH  default 1  bits per operand and per result
// PORTS
//  clk        in   1            rising-edge clock
//  rst        in   1            synchronous, active-high reset
//  in_valid   in   1            operand set + op are valid
//  in_ready   out  1            block accepts input this cycle
//  in_data    in   N_IN*WIDTH   operand k = in_data[k*WIDTH +: WIDTH]
//  in_op      in   3            gate select, sampled with in_data
//  out_valid  out  1            out_data is valid
//  out_ready  in   1            consumer accepts output
//  out_data   out  WIDTH        bit-wise reduction result
//  out_err    out  1            result came from an illegal op code
// BEHAVIOUR
//  - Reset: both stage valids, out_valid, out_data, out_err = 0. Reset has
//    priority over everything; in-flight data is discarded, nothing emitted.
//  - Op codes: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR.
//    110/111 illegal: out_data = 0, out_err = 1 for that result only.
//  - Per bit i: out_data[i] = op applied across operand[0..N_IN-1] bit i.
//    XOR = odd parity of the N_IN bits; XNOR = its inverse.
//  - Pipeline: S1 registers in_data/in_op/valid; S2 computes and registers result.
//  - Global advance: adv = ~out_valid | out_ready. in_ready = adv (combinational).
//  - Input transfer when in_valid & in_ready; output transfer when
//    out_valid & out_ready.
//  - On adv: S1 <= input (valid = in_valid), S2 <= f(S1) (valid = S1 valid).
//    When adv = 0 all stage registers hold; out_data stable while out_valid & ~out_ready.
//  - Latency: accepted at edge T -> out_valid at edge T+2 (no stall).
//  - Throughput: 1 result/cycle with out_ready held high; no bubbles inserted.
//  - Bubbles (S1 empty) propagate; out_valid drops without losing ordering.
//  - Simultaneous output accept and new input in the same cycle: both transfer.
//  - in_op is sampled only on transfer; changes while stalled have no effect.
// CONFIGURATION
//  LOGIC_REDUCE_PARITY_EN:
//   defined   -> extra output port out_par (1 bit) = ^out_data, same timing as
//                out_data, reset 0.
//   undefined -> port out_par absent; behaviour otherwise identical.
// TESTING (N_IN=3, WIDTH=4 unless stated)
//  1. rst=1 for 2 cycles, then release -> out_valid=0, out_data=0, out_err=0, in_ready=1.
//  2. op=000, data {F,F,F} then {F,7,F}, out_ready=1 -> out_data F then 7 at T+2, T+3.
//  3. N_IN=3, WIDTH=1 exhaustive sweep of 8 inputs x 6 legal ops, back-to-back ->
//     each result matches the gate truth table, 1 per cycle, order preserved.
//  4. op=010 {A,C,3} -> out_data 5; out_ready=0 for 3 cycles -> out_data held at 5,
//     in_ready=0, no input lost when released.
//  5. op=111 {F,F,F} -> out_data 0, out_err=1; next op=001 {1,2,4} -> 7, out_err=0.
//  6. rst pulse while 2 results in flight -> out_valid=0 next cycle, no stale output;
//     with LOGIC_REDUCE_PARITY_EN, out_par = ^out_data on every valid result.

Source files
------------

// File: rtl/logic_reduce_pipe.sv
// Pipelined N_IN-operand bit-wise gate reduction with a valid/ready handshake and 2 register stages.
// Optional out_par output (XOR of out_data) when LOGIC_REDUCE_PARITY_EN is defined.

module logic_reduce_lane #(
    parameter int N_IN = 3
) (
    input  logic [N_IN-1:0] bits,
    input  logic [2:0]      op,
    output logic            y
);
    always_comb begin
        y = 1'b0;
        case (op)
            3'b000:  y = &bits;
            3'b001:  y = |bits;
            3'b010:  y = ^bits;
            3'b011:  y = ~&bits;
            3'b100:  y = ~|bits;
            3'b101:  y = ~^bits;
            default: y = 1'b0;
        endcase
    end
endmodule

module logic_reduce_pipe #(
    parameter int N_IN  = 3,
    parameter int WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [2:0]            in_op,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_err
`ifdef LOGIC_REDUCE_PARITY_EN
    ,
    output logic                  out_par
`endif
);
    // vld_pipe[0] is the S1 valid, vld_pipe[STAGES] is the output valid.
    localparam int STAGES = 1;

    logic [STAGES:0]              vld_pipe;
    logic                         adv;
    logic [N_IN*WIDTH-1:0]        s1_data;
    logic [2:0]                   s1_op;
    logic [WIDTH-1:0][N_IN-1:0]   lane_bits;
    logic [WIDTH-1:0]             lane_y;

    assign adv       = ~vld_pipe[STAGES] | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_pipe[STAGES];

    always_ff @(posedge clk) begin
        if (rst)
            vld_pipe <= '0;
        else if (adv)
            vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
    end

    // Operands and op are captured only on a real transfer, so stalled changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data <= '0;
            s1_op   <= '0;
        end else if (adv && in_valid) begin
            s1_data <= in_data;
            s1_op   <= in_op;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        for (genvar k = 0; k < N_IN; k++) begin : g_opnd
            assign lane_bits[i][k] = s1_data[k*WIDTH + i];
        end
        logic_reduce_lane #(.N_IN(N_IN)) u_lane (
            .bits (lane_bits[i]),
            .op   (s1_op),
            .y    (lane_y[i])
        );
    end

    // Result registers only load real results so out_data stays put across bubbles and stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            out_err  <= 1'b0;
        end else if (adv && vld_pipe[0]) begin
            out_data <= lane_y;
            out_err  <= s1_op[2] & s1_op[1];
        end
    end

`ifdef LOGIC_REDUCE_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst)
            out_par <= 1'b0;
        else if (adv && vld_pipe[0])
            out_par <= ^lane_y;
    end
`endif

endmodule

// File: tb/tb_logic_reduce_pipe.sv
// Randomized and directed bench for logic_reduce_pipe (N_IN=3, WIDTH=4) with a counting-based
// reference model and an in-order scoreboard.

module tb_logic_reduce_pipe;
    localparam int N  = 3;
    localparam int W  = 4;
    localparam int DW = N*W;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [2:0]    in_op;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_err;
`ifdef LOGIC_REDUCE_PARITY_EN
    logic          out_par;
`endif

    logic_reduce_pipe #(.N_IN(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
`ifdef LOGIC_REDUCE_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic         err;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    int           n_chk  = 0;
    int           n_fail = 0;
    int           cycle  = 0;
    int           last_stall = -1;
    logic         prev_rst   = 1'b0;
    logic         hold_vld   = 1'b0;
    logic [W-1:0] hold_data  = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cycle, got, exp);
        end
    endtask

    // Reference: count the ones in each bit column and apply the gate definition to the count.
    function automatic void model(input logic [DW-1:0] d, input logic [2:0] op,
                                  output logic [W-1:0] r, output logic e);
        r = '0;
        e = (op >= 3'd6);
        for (int i = 0; i < W; i++) begin
            int cnt;
            cnt = 0;
            for (int k = 0; k < N; k++) cnt += int'(d[k*W + i]);
            case (op)
                3'd0: r[i] = (cnt == N);
                3'd1: r[i] = (cnt > 0);
                3'd2: r[i] = (cnt % 2 == 1);
                3'd3: r[i] = (cnt != N);
                3'd4: r[i] = (cnt == 0);
                3'd5: r[i] = (cnt % 2 == 0);
                default: r[i] = 1'b0;
            endcase
        end
    endfunction

    // One clock cycle: drive after the edge, observe at the falling edge.
    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic [2:0] o,
                       input logic r, input logic rs);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = v; in_data = d; in_op = o; out_ready = r; rst = rs;
        @(negedge clk);
        cycle++;
        if (prev_rst) begin
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_out_data", 32'(out_data), 32'd0);
            chk("rst_out_err", 32'(out_err), 32'd0);
        end
        prev_rst = rs;
        if (rs) begin
            sb.delete();
            hold_vld = 1'b0;
        end else begin
            chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
            if (out_valid && hold_vld) chk("hold_data", 32'(out_data), 32'(hold_data));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_out", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", 32'(out_data), 32'(e.data));
                    chk("out_err", 32'(out_err), 32'(e.err));
`ifdef LOGIC_REDUCE_PARITY_EN
                    chk("out_par", 32'(out_par), 32'(^e.data));
`else
                    chk("no_par_err_dup", 32'(out_err && (out_data != '0)), 32'd0);
`endif
                    if (last_stall < e.cyc) chk("latency", 32'(cycle - e.cyc), 32'd2);
                end
            end
            hold_vld  = out_valid && !out_ready;
            hold_data = out_data;
            if (hold_vld) last_stall = cycle;
            if (in_valid && in_ready) begin
                model(in_data, in_op, e.data, e.err);
                e.cyc = cycle;
                sb.push_back(e);
            end
        end
    endtask

    initial begin
        logic [DW-1:0] d;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_op = '0; out_ready = 1'b1;

        // Reset and idle state
        cyc(0, '0, 3'd0, 1, 1);
        cyc(0, '0, 3'd0, 1, 1);
        cyc(0, '0, 3'd0, 1, 0);
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // AND back-to-back: F then 7
        cyc(1, 12'hFFF, 3'd0, 1, 0);
        cyc(1, 12'hF7F, 3'd0, 1, 0);
        repeat (3) cyc(0, '0, 3'd0, 1, 0);

        // Every 3-bit column combination under every legal op, back-to-back
        for (int op = 0; op < 6; op++) begin
            for (int c = 0; c < 8; c++) begin
                d = '0;
                for (int k = 0; k < N; k++)
                    for (int i = 0; i < W; i++)
                        d[k*W + i] = 1'(((c + i) % 8) >> k);
                cyc(1, d, 3'(op), 1, 0);
            end
        end
        repeat (3) cyc(0, '0, 3'd0, 1, 0);

        // XOR {A,C,3} -> 5, then 3 cycles of backpressure with a pending input
        cyc(1, 12'hAC3, 3'd2, 1, 0);
        cyc(0, '0, 3'd0, 1, 0);
        cyc(1, 12'h123, 3'd1, 0, 0);
        cyc(1, 12'h456, 3'd6, 0, 0);
        cyc(1, 12'h789, 3'd3, 0, 0);
        cyc(1, 12'h789, 3'd3, 1, 0);
        repeat (4) cyc(0, '0, 3'd0, 1, 0);

        // Illegal op then OR {1,2,4}
        cyc(1, 12'hFFF, 3'd7, 1, 0);
        cyc(1, 12'h124, 3'd1, 1, 0);
        repeat (3) cyc(0, '0, 3'd0, 1, 0);

        // Reset with two results in flight
        cyc(1, 12'h5A5, 3'd2, 1, 0);
        cyc(1, 12'hA5A, 3'd5, 1, 0);
        cyc(0, '0, 3'd0, 1, 1);
        repeat (4) cyc(0, '0, 3'd0, 1, 0);

        // Random traffic with random backpressure and rare resets
        for (int n = 0; n < 800; n++) begin
            cyc(1'($urandom_range(0, 3) != 0), DW'($urandom), 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 99) == 0));
        end

        // Drain within a bounded number of cycles
        repeat (10) cyc(0, '0, 3'd0, 1, 0);
        chk("drain_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
